// File: rtl/calendar_pkg.sv
// Shared types, limits and the month-length helper for the calendar/alarm core.
//   alarm_state_t   : per-channel alarm state
//   days_in_month() : month length from month number (1..12) and leap flag
package calendar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HRS_MAX  = 5'd23;
  localparam logic [2:0] DAY_SAT  = 3'd6;
  localparam logic [2:0] WKDAY_LO = 3'd1;
  localparam logic [2:0] WKDAY_HI = 3'd5;

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                      days_in_month = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
      default:                   days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: alarm time registers, ring/snooze state machine and the
// minute-boundary counter shared by the ringing and snoozed states.
// Ports:
//   clk_sys, rst_b       : clock, synchronous active-low reset
//   min_adv, hrs_adv     : advance this channel's alarm minute / hour (pre-qualified)
//   match                : alarm time reached on this minute boundary
//   min_tick             : minute boundary strobe
//   snooze, off          : user strobes (off wins)
//   enable               : channel enabled; low forces IDLE
//   alarm_min, alarm_hrs : alarm setting
//   ringing              : registered ringing flag
//
// state   | meaning
// IDLE    | waiting for a match
// RINGING | buzzing; cnt = minute boundaries left before self-clear
// SNOOZED | silent; cnt = minute boundaries left before re-ring
module alarm_channel
  import calendar_pkg::*;
#(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_MIN   = 1
) (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       min_adv,
  input  logic       hrs_adv,
  input  logic       match,
  input  logic       min_tick,
  input  logic       snooze,
  input  logic       off,
  input  logic       enable,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hrs,
  output logic       ringing
);

  localparam int CNT_MAX = (SNOOZE_MIN > RING_MIN) ? SNOOZE_MIN : RING_MIN;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LD = CNT_W'(RING_MIN);
  localparam logic [CNT_W-1:0] SNZ_LD  = CNT_W'(SNOOZE_MIN);

  alarm_state_t     state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      alarm_min <= '0;
      alarm_hrs <= '0;
      state     <= IDLE;
      cnt       <= '0;
      ringing   <= 1'b0;
    end else begin
      if (min_adv) alarm_min <= (alarm_min == MIN_MAX) ? 6'd0 : alarm_min + 6'd1;
      if (hrs_adv) alarm_hrs <= (alarm_hrs == HRS_MAX) ? 5'd0 : alarm_hrs + 5'd1;

      if (!enable) begin
        state   <= IDLE;
        ringing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (match) begin
              state   <= RINGING;
              ringing <= 1'b1;
              cnt     <= RING_LD;
            end
          end
          RINGING: begin
            if (off) begin
              state   <= IDLE;
              ringing <= 1'b0;
            end else if (snooze) begin
              state   <= SNOOZED;
              ringing <= 1'b0;
              cnt     <= SNZ_LD;
            end else if (min_tick) begin
              // the boundary that would take the count to zero ends the ring
              if (cnt <= CNT_W'(1)) begin
                state   <= IDLE;
                ringing <= 1'b0;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          SNOOZED: begin
            if (off) begin
              state <= IDLE;
            end else if (match || (min_tick && cnt <= CNT_W'(1))) begin
              state   <= RINGING;
              ringing <= 1'b1;
              cnt     <= RING_LD;
            end else if (min_tick) begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            ringing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/calendar_alarm_core.sv
// Calendar (seconds..year, day-of-week, leap February) plus NUM_ALARMS alarm
// channels, all advanced by a one-second strobe on the system clock.
// Ports:
//   Clk, Reset                     : clock, synchronous active-low reset
//   Tick                           : one-second strobe
//   Timeset, Alarmset, Alarmsel    : mode levels and alarm select
//   Minadv..Yearadv                : one-cycle field advance strobes
//   Alarmon, Alarmwkday            : per-alarm enable / Mon-Fri-only
//   Snooze, Alarmoff               : strobes applied to every channel
//   Sec..Year                      : calendar fields
//   AlarmMin, AlarmHrs             : setting of alarm[Alarmsel]
//   Buzz, BuzzId                   : any ringing / lowest ringing index
module calendar_alarm_core
  import calendar_pkg::*;
#(
  parameter  int NUM_ALARMS = 2,
  parameter  int YEAR_MOD   = 100,
  parameter  int SNOOZE_MIN = 9,
  parameter  int RING_MIN   = 1,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int YR_W       = $clog2(YEAR_MOD)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  Timeset,
  input  logic                  Alarmset,
  input  logic [SEL_W-1:0]      Alarmsel,
  input  logic                  Minadv,
  input  logic                  Hrsadv,
  input  logic                  Dayadv,
  input  logic                  Dateadv,
  input  logic                  Monthadv,
  input  logic                  Yearadv,
  input  logic [NUM_ALARMS-1:0] Alarmon,
  input  logic [NUM_ALARMS-1:0] Alarmwkday,
  input  logic                  Snooze,
  input  logic                  Alarmoff,
  output logic [5:0]            Sec,
  output logic [5:0]            Min,
  output logic [4:0]            Hrs,
  output logic [2:0]            Day,
  output logic [4:0]            Date,
  output logic [3:0]            Month,
  output logic [YR_W-1:0]       Year,
  output logic [5:0]            AlarmMin,
  output logic [4:0]            AlarmHrs,
  output logic                  Buzz,
  output logic [SEL_W-1:0]      BuzzId
);

  logic [4:0]      dim_cur, dim_new;
  logic            minute_tick, hour_tick, day_tick, month_tick, year_tick;
  logic [5:0]      sec_run, min_run;
  logic [4:0]      hrs_run, date_run, date_set;
  logic [2:0]      day_run;
  logic [3:0]      month_run, month_set;
  logic [YR_W-1:0] year_run, year_set, year_inc;

  assign dim_cur  = days_in_month(Month, Year[1:0] == 2'd0);
  assign year_inc = (Year == YR_W'(YEAR_MOD - 1)) ? '0 : Year + YR_W'(1);

  // carry chain for run mode; minute_tick is also the alarm minute boundary
  assign minute_tick = !Timeset && Tick && (Sec == SEC_MAX);
  assign hour_tick   = minute_tick && (Min == MIN_MAX);
  assign day_tick    = hour_tick && (Hrs == HRS_MAX);
  assign month_tick  = day_tick && (Date >= dim_cur);
  assign year_tick   = month_tick && (Month == 4'd12);

  assign sec_run   = Tick ? ((Sec == SEC_MAX) ? 6'd0 : Sec + 6'd1) : Sec;
  assign min_run   = minute_tick ? ((Min == MIN_MAX) ? 6'd0 : Min + 6'd1) : Min;
  assign hrs_run   = hour_tick ? ((Hrs == HRS_MAX) ? 5'd0 : Hrs + 5'd1) : Hrs;
  assign day_run   = day_tick ? ((Day == DAY_SAT) ? 3'd0 : Day + 3'd1) : Day;
  assign date_run  = day_tick ? (month_tick ? 5'd1 : Date + 5'd1) : Date;
  assign month_run = month_tick ? ((Month == 4'd12) ? 4'd1 : Month + 4'd1) : Month;
  assign year_run  = year_tick ? year_inc : Year;

  // set mode: each field wraps on its own; Date then clamps to the new month
  assign month_set = Monthadv ? ((Month == 4'd12) ? 4'd1 : Month + 4'd1) : Month;
  assign year_set  = Yearadv ? year_inc : Year;
  assign dim_new   = days_in_month(month_set, year_set[1:0] == 2'd0);

  always_comb begin
    date_set = Date;
    if (Dateadv) date_set = (Date >= dim_cur) ? 5'd1 : Date + 5'd1;
    if (date_set > dim_new) date_set = dim_new;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Sec   <= '0;
      Min   <= '0;
      Hrs   <= '0;
      Day   <= DAY_SAT;
      Date  <= 5'd1;
      Month <= 4'd1;
      Year  <= '0;
    end else if (Timeset) begin
      Sec   <= '0;
      if (Minadv) Min <= (Min == MIN_MAX) ? 6'd0 : Min + 6'd1;
      if (Hrsadv) Hrs <= (Hrs == HRS_MAX) ? 5'd0 : Hrs + 5'd1;
      if (Dayadv) Day <= (Day == DAY_SAT) ? 3'd0 : Day + 3'd1;
      Date  <= date_set;
      Month <= month_set;
      Year  <= year_set;
    end else begin
      Sec   <= sec_run;
      Min   <= min_run;
      Hrs   <= hrs_run;
      Day   <= day_run;
      Date  <= date_run;
      Month <= month_run;
      Year  <= year_run;
    end
  end

  logic [5:0]            alarm_min [NUM_ALARMS];
  logic [4:0]            alarm_hrs [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match, ring;
  logic                  wkday_next;

  assign wkday_next = (day_run >= WKDAY_LO) && (day_run <= WKDAY_HI);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    logic sel_hit;
    assign sel_hit  = Alarmset && !Timeset && (Alarmsel == SEL_W'(i));
    // compare against the time the edge is about to show, so Buzz lands on xx:xx:00
    assign match[i] = minute_tick && Alarmon[i] &&
                      (alarm_min[i] == min_run) && (alarm_hrs[i] == hrs_run) &&
                      (!Alarmwkday[i] || wkday_next);

    alarm_channel #(
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_MIN  (RING_MIN)
    ) u_chan (
      .clk_sys  (Clk),
      .rst_b    (Reset),
      .min_adv  (sel_hit && Minadv),
      .hrs_adv  (sel_hit && Hrsadv),
      .match    (match[i]),
      .min_tick (minute_tick),
      .snooze   (Snooze),
      .off      (Alarmoff),
      .enable   (Alarmon[i]),
      .alarm_min(alarm_min[i]),
      .alarm_hrs(alarm_hrs[i]),
      .ringing  (ring[i])
    );
  end

  assign Buzz = |ring;

  always_comb begin
    AlarmMin = '0;
    AlarmHrs = '0;
    BuzzId   = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (Alarmsel == SEL_W'(i)) begin
        AlarmMin = alarm_min[i];
        AlarmHrs = alarm_hrs[i];
      end
    end
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring[i]) BuzzId = SEL_W'(i);
    end
  end

endmodule

// File: tb/tb_calendar_alarm_core.sv
module tb_calendar_alarm_core;
  localparam int NA = 2;
  localparam int YM = 100;

  logic clk = 1'b0;
  logic reset = 1'b0, tick = 1'b0, timeset = 1'b0, alarmset = 1'b0;
  logic [0:0] alarmsel = '0;
  logic minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0, dateadv = 1'b0, monthadv = 1'b0, yearadv = 1'b0;
  logic [NA-1:0] alarmon = '0, alarmwkday = '0;
  logic snooze = 1'b0, alarmoff = 1'b0;
  logic [5:0] sec, min, almin;
  logic [4:0] hrs, date, alhrs;
  logic [2:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic buzz;
  logic [0:0] buzzid;

  always #5 clk = ~clk;

  calendar_alarm_core #(.NUM_ALARMS(NA), .YEAR_MOD(YM), .SNOOZE_MIN(9), .RING_MIN(1)) dut (
    .Clk(clk), .Reset(reset), .Tick(tick), .Timeset(timeset), .Alarmset(alarmset),
    .Alarmsel(alarmsel), .Minadv(minadv), .Hrsadv(hrsadv), .Dayadv(dayadv),
    .Dateadv(dateadv), .Monthadv(monthadv), .Yearadv(yearadv), .Alarmon(alarmon),
    .Alarmwkday(alarmwkday), .Snooze(snooze), .Alarmoff(alarmoff), .Sec(sec), .Min(min),
    .Hrs(hrs), .Day(day), .Date(date), .Month(month), .Year(year), .AlarmMin(almin),
    .AlarmHrs(alhrs), .Buzz(buzz), .BuzzId(buzzid));

  int n_checks = 0, n_pass = 0;
  int m_sec, m_min, m_hrs, m_day, m_date, m_mon, m_year;
  int am[NA], ah[NA];

  typedef struct {
    int ts, mi, hr, dy, dt, mo, yr, tk;
    int e_sec, e_min, e_hrs, e_day, e_date, e_mon, e_year;
  } vec_t;
  vec_t vt[8];

  function automatic int dim(int m, int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_time(string name, int s, int mi, int h, int dy, int dt, int mo, int y);
    n_checks++;
    if (int'(sec) == s && int'(min) == mi && int'(hrs) == h && int'(day) == dy &&
        int'(date) == dt && int'(month) == mo && int'(year) == y) n_pass++;
    else $display("FAIL %s: got %0d:%0d:%0d d%0d %0d/%0d y%0d expected %0d:%0d:%0d d%0d %0d/%0d y%0d",
                  name, hrs, min, sec, day, month, date, year, h, mi, s, dy, mo, dt, y);
  endtask

  // behavioural model: time of day as a seconds count, calendar as y/m/d
  task automatic model_update();
    int tod, s;
    if (!reset) begin
      m_sec = 0; m_min = 0; m_hrs = 0; m_day = 6; m_date = 1; m_mon = 1; m_year = 0;
      for (int i = 0; i < NA; i++) begin am[i] = 0; ah[i] = 0; end
    end else if (timeset) begin
      int d;
      m_sec = 0;
      if (minadv) m_min = (m_min + 1) % 60;
      if (hrsadv) m_hrs = (m_hrs + 1) % 24;
      if (dayadv) m_day = (m_day + 1) % 7;
      d = m_date;
      if (dateadv) d = (d >= dim(m_mon, m_year)) ? 1 : d + 1;
      if (monthadv) m_mon = m_mon % 12 + 1;
      if (yearadv) m_year = (m_year + 1) % YM;
      if (d > dim(m_mon, m_year)) d = dim(m_mon, m_year);
      m_date = d;
    end else begin
      if (alarmset) begin
        s = int'(alarmsel);
        if (minadv) am[s] = (am[s] + 1) % 60;
        if (hrsadv) ah[s] = (ah[s] + 1) % 24;
      end
      if (tick) begin
        tod = m_hrs * 3600 + m_min * 60 + m_sec + 1;
        if (tod == 86400) begin
          tod = 0;
          m_day = (m_day + 1) % 7;
          m_date++;
          if (m_date > dim(m_mon, m_year)) begin
            m_date = 1;
            m_mon++;
            if (m_mon > 12) begin m_mon = 1; m_year = (m_year + 1) % YM; end
          end
        end
        m_hrs = tod / 3600; m_min = (tod / 60) % 60; m_sec = tod % 60;
      end
    end
  endtask

  task automatic step();
    bit quiet;
    int s;
    quiet = !reset || (alarmon == '0);
    model_update();
    @(posedge clk); #1;
    s = int'(alarmsel);
    n_checks++;
    if (int'(sec) == m_sec && int'(min) == m_min && int'(hrs) == m_hrs && int'(day) == m_day &&
        int'(date) == m_date && int'(month) == m_mon && int'(year) == m_year &&
        int'(almin) == am[s] && int'(alhrs) == ah[s]) n_pass++;
    else $display("FAIL model t=%0t: got %0d:%0d:%0d d%0d %0d/%0d y%0d al %0d:%0d expected %0d:%0d:%0d d%0d %0d/%0d y%0d al %0d:%0d",
                  $time, hrs, min, sec, day, month, date, year, alhrs, almin,
                  m_hrs, m_min, m_sec, m_day, m_mon, m_date, m_year, ah[s], am[s]);
    if (quiet) chk("buzz_quiet", int'(buzz), 0);
    tick = 0; minadv = 0; hrsadv = 0; dayadv = 0; dateadv = 0; monthadv = 0; yearadv = 0;
    snooze = 0; alarmoff = 0;
  endtask

  task automatic run_ticks(int n);
    repeat (n) begin tick = 1; step(); end
  endtask

  task automatic goto_time(int y, int mo, int d, int h, int mi);
    timeset = 1;
    while (m_year != y) begin yearadv = 1; step(); end
    while (m_mon != mo) begin monthadv = 1; step(); end
    while (m_date != d) begin dateadv = 1; step(); end
    while (m_hrs != h) begin hrsadv = 1; step(); end
    while (m_min != mi) begin minadv = 1; step(); end
    timeset = 0;
  endtask

  task automatic set_day(int d);
    timeset = 1;
    while (m_day != d) begin dayadv = 1; step(); end
    timeset = 0;
  endtask

  task automatic set_alarm(int idx, int h, int mi);
    alarmset = 1; alarmsel = 1'(idx);
    while (ah[idx] != h) begin hrsadv = 1; step(); end
    while (am[idx] != mi) begin minadv = 1; step(); end
    alarmset = 0;
  endtask

  initial begin
    bit seen;
    int cyc;
    vt[0] = '{0,0,0,0,0,0,0,1, 1,0,0,6,1,1,0};
    vt[1] = '{0,1,0,0,0,0,0,1, 2,0,0,6,1,1,0};
    vt[2] = '{1,1,0,0,0,0,0,1, 0,1,0,6,1,1,0};
    vt[3] = '{1,0,1,1,0,0,0,0, 0,1,1,0,1,1,0};
    vt[4] = '{1,0,0,0,1,0,0,0, 0,1,1,0,2,1,0};
    vt[5] = '{1,0,0,0,0,1,1,0, 0,1,1,0,2,2,1};
    vt[6] = '{0,0,0,0,0,0,0,0, 0,1,1,0,2,2,1};
    vt[7] = '{0,0,0,0,0,0,0,1, 1,1,1,0,2,2,1};

    // reset
    reset = 0; step();
    chk_time("reset", 0, 0, 0, 6, 1, 1, 0);
    chk("reset_buzz", int'(buzz), 0);
    chk("reset_buzzid", int'(buzzid), 0);
    reset = 1;

    foreach (vt[k]) begin
      timeset = vt[k].ts != 0; minadv = vt[k].mi != 0; hrsadv = vt[k].hr != 0;
      dayadv = vt[k].dy != 0; dateadv = vt[k].dt != 0; monthadv = vt[k].mo != 0;
      yearadv = vt[k].yr != 0; tick = vt[k].tk != 0;
      step();
      chk_time($sformatf("vec%0d", k), vt[k].e_sec, vt[k].e_min, vt[k].e_hrs, vt[k].e_day,
               vt[k].e_date, vt[k].e_mon, vt[k].e_year);
    end
    timeset = 0;

    // year rollover
    set_day(6);
    goto_time(0, 12, 31, 23, 59);
    run_ticks(59);
    chk_time("pre_newyear", 59, 59, 23, 6, 31, 12, 0);
    run_ticks(1);
    chk_time("newyear", 0, 0, 0, 0, 1, 1, 1);

    // leap and non-leap February
    goto_time(4, 2, 28, 23, 59); run_ticks(60);
    chk("leap_date", int'(date), 29); chk("leap_month", int'(month), 2);
    goto_time(5, 2, 28, 23, 59); run_ticks(60);
    chk("nonleap_date", int'(date), 1); chk("nonleap_month", int'(month), 3);
    goto_time(5, 1, 31, 0, 0);
    timeset = 1; monthadv = 1; step(); timeset = 0;
    chk("clamp_date", int'(date), 28); chk("clamp_month", int'(month), 2);

    // alarm 0 at 07:00, snooze then timeout
    set_alarm(0, 7, 0);
    alarmon = 2'b01; alarmwkday = 2'b00;
    goto_time(5, 3, 1, 6, 59); run_ticks(59);
    chk("pre_alarm_buzz", int'(buzz), 0);
    run_ticks(1);
    chk("ring_buzz", int'(buzz), 1); chk("ring_id", int'(buzzid), 0);
    chk("ring_time", int'(hrs) * 60 + int'(min), 7 * 60);
    run_ticks(30);
    chk("ring_0030", int'(buzz), 1);
    snooze = 1; step();
    chk("snoozed", int'(buzz), 0);
    run_ticks(8 * 60 + 29);
    chk("snooze_0859", int'(buzz), 0);
    run_ticks(1);
    chk("rering_0900", int'(buzz), 1);
    run_ticks(59);
    chk("rering_0959", int'(buzz), 1);
    run_ticks(1);
    chk("timeout_1000", int'(buzz), 0);

    // weekday-only alarm 1 at 06:30
    alarmon = 2'b10; alarmwkday = 2'b10;
    set_alarm(1, 6, 30);
    set_day(6);
    goto_time(5, 3, 1, 6, 29); run_ticks(60);
    chk("wkday_sat", int'(buzz), 0);
    set_day(1);
    goto_time(5, 3, 1, 6, 29); run_ticks(60);
    chk("wkday_mon", int'(buzz), 1); chk("wkday_mon_id", int'(buzzid), 1);
    alarmoff = 1; step();
    chk("alarmoff", int'(buzz), 0);

    // both alarms match; Snooze and Alarmoff together
    set_alarm(0, 6, 30);
    alarmon = 2'b11;
    goto_time(5, 3, 1, 6, 29); run_ticks(60);
    chk("both_buzz", int'(buzz), 1); chk("both_id", int'(buzzid), 0);
    snooze = 1; alarmoff = 1; step();
    chk("both_off", int'(buzz), 0); chk("both_off_id", int'(buzzid), 0);
    seen = 0;
    repeat (600) begin tick = 1; step(); if (buzz) seen = 1; end
    chk("both_stay_idle", int'(seen), 0);

    // reset while ringing
    goto_time(5, 3, 1, 6, 29); run_ticks(60);
    chk("ring_before_reset", int'(buzz), 1);
    reset = 0; step(); reset = 1;
    chk("reset_ring_buzz", int'(buzz), 0);
    chk_time("reset_ring", 0, 0, 0, 6, 1, 1, 0);
    chk("reset_alarm", int'(alhrs) * 60 + int'(almin), 0);

    // randomized phases against the model, alarms disabled
    alarmon = '0;
    cyc = 0;
    while (cyc < 20000) begin
      int mode, len;
      mode = $urandom_range(0, 2);
      len = $urandom_range(1, 120);
      repeat (len) begin
        reset = ($urandom_range(0, 999) != 0);
        timeset = (mode == 0);
        alarmset = (mode == 2) || ($urandom_range(0, 3) == 0);
        alarmsel = 1'($urandom_range(0, 1));
        tick = (mode == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
        minadv = ($urandom_range(0, 2) == 0); hrsadv = ($urandom_range(0, 2) == 0);
        dayadv = ($urandom_range(0, 2) == 0); dateadv = ($urandom_range(0, 2) == 0);
        monthadv = ($urandom_range(0, 2) == 0); yearadv = ($urandom_range(0, 2) == 0);
        snooze = ($urandom_range(0, 3) == 0); alarmoff = ($urandom_range(0, 3) == 0);
        alarmwkday = 2'($urandom_range(0, 3));
        step();
        cyc++;
      end
    end
    reset = 1; timeset = 0; alarmset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calendar_alarm_core.md
# calendar_alarm_core

Parametrised calendar/alarm datapath: seconds through year with leap-year February, day-of-week, and `NUM_ALARMS` independent alarms with weekday-only mode, snooze and auto-timeout. It is the successor to the single-alarm day/date/month clock core. It emits binary fields, and the existing 7-segment display decoders sit downstream. All counting is gated by a one-second strobe, so the core runs on the system clock.

## Interface
- `NUM_ALARMS`, 2: number of alarm channels (1-8)
- `YEAR_MOD`, 100: year counter modulus (year 0 = 2000)
- `SNOOZE_MIN`, 9: snooze length in minute boundaries
- `RING_MIN`, 1: minute boundaries before an unanswered alarm self-clears
- `Clk` in 1: system clock
- `Reset` in 1: reset, synchronous, active-low
- `Tick` in 1: one-second strobe, one `Clk` wide
- `Timeset` in 1: level; set-time mode
- `Alarmset` in 1: level; set-alarm mode
- `Alarmsel` in $clog2(NUM_ALARMS) (min 1): alarm addressed by `Alarmset` and by the alarm outputs
- `Minadv`, `Hrsadv`, `Dayadv`, `Dateadv`, `Monthadv`, `Yearadv` in 1 each: one-cycle advance strobes
- `Alarmon` in NUM_ALARMS: per-alarm enable
- `Alarmwkday` in NUM_ALARMS: per-alarm Mon-Fri-only mode
- `Snooze`, `Alarmoff` in 1 each: one-cycle strobes
- `Sec` out 6, `Min` out 6, `Hrs` out 5, `Day` out 3 (0 = Sun), `Date` out 5, `Month` out 4, `Year` out $clog2(YEAR_MOD)
- `AlarmMin` out 6, `AlarmHrs` out 5: alarm[`Alarmsel`] setting
- `Buzz` out 1: any alarm ringing
- `BuzzId` out $clog2(NUM_ALARMS): lowest ringing index; 0 when `Buzz` = 0

## Operation
- Reset values:
  - Time and calendar: 00:00:00, `Day` = 6 (Sat), `Date` = 1, `Month` = 1, `Year` = 0.
  - All alarms: 00:00, state IDLE.
  - `Buzz` = 0, `BuzzId` = 0.
- Run mode (`Timeset` = 0):
  - On `Tick`, `Sec` increments; 59→0 carries to `Min`.
  - `Min` 59→0 carries to `Hrs`.
  - `Hrs` 23→0 increments `Day` mod 7 and `Date`.
  - `Date` = dim(month, year) → 1 and `Month` increments.
  - `Month` 12→1 increments `Year` mod `YEAR_MOD`.
  - dim: Feb = 29 when `Year`%4 = 0, else 28. Apr/Jun/Sep/Nov = 30. Others = 31.
  - Advance strobes are ignored in run mode unless `Alarmset` = 1.
- Set-time mode (`Timeset` = 1):
  - `Tick` is ignored and `Sec` is forced to 0.
  - Each advance strobe increments its field by one with wrap and no carry: Min mod 60, Hrs mod 24, Day mod 7, Date 1..dim, Month 1..12, Year mod `YEAR_MOD`.
  - After a Month or Year advance, `Date` clamps to the new dim.
  - `Timeset` has priority over `Alarmset`.
- Set-alarm mode (`Alarmset` = 1, `Timeset` = 0): `Minadv`/`Hrsadv` wrap alarm[`Alarmsel`] min/hrs. Time keeps running.
- Alarm FSM per channel, states IDLE, RINGING, SNOOZED:
  - Match: a `Tick` edge that makes `Sec` = 0 with next Hrs:Min = alarm, `Alarmon[i]` = 1, and (`Alarmwkday[i]` = 0 or next `Day` in 1..5).
  - IDLE→RINGING on match; the ring counter loads `RING_MIN`.
  - RINGING→SNOOZED on `Snooze`; the snooze counter loads `SNOOZE_MIN`.
  - RINGING→IDLE on `Alarmoff`, or when the ring counter hits 0 (it decrements on each minute boundary).
  - SNOOZED→RINGING when the snooze counter hits 0 (decrements on each minute boundary); the ring counter reloads.
  - SNOOZED→RINGING immediately on a fresh match, with the ring counter reloaded.
  - SNOOZED→IDLE on `Alarmoff`.
  - Any state→IDLE when `Alarmon[i]` = 0.
  - `Snooze` and `Alarmoff` act on all channels; `Alarmoff` wins if both strobes arrive together.
  - No matches and no minute boundaries occur while `Timeset` = 1. Counters hold.

## Timing
- All outputs are registered. Field updates appear on the `Clk` edge that samples `Tick` or a strobe, so latency is 1 cycle.
- `Buzz` rises on the same edge on which `Sec`/`Min` show the matching minute (xx:xx:00).
- Strobes are single-cycle. A strobe held N cycles produces N advances.
- `Reset` low on any edge returns all state to reset values, overriding every other input.

## Structure
- `calendar_pkg` holds:
  - `alarm_state_t` (IDLE, RINGING, SNOOZED)
  - `days_in_month(month, leap)` function
  - constants `SEC_MAX` = 59, `MIN_MAX` = 59, `HRS_MAX` = 23, `DAY_SAT` = 6, `WKDAY_LO` = 1, `WKDAY_HI` = 5
- Sub-module `alarm_channel`:
  - Holds the alarm regs, FSM and ring/snooze counters.
  - Instantiated `NUM_ALARMS` times by generate.
  - Inputs: match, minute boundary, snooze, off, enable.
  - Output: ringing.

## Test plan
- Reset low 1 cycle → 00:00:00, Sat, 01/01, year 0, `Buzz` 0.
- Set 12/31 23:59:59 year 0, one `Tick` → 00:00:00, 01/01, year 1, `Day` +1.
- Year 4: Feb 28 23:59:59 + `Tick` → Feb 29. Year 5: same stimulus → Mar 01. Month advance from Jan 31 to Feb in year 5 → `Date` clamps to 28.
- Alarm0 = 07:00 on, time 06:59:59 + `Tick` → `Buzz` = 1, `BuzzId` = 0. `Snooze` at 07:00:30 → `Buzz` 0, re-rings at 07:09:00. No action → clears at 07:10:00.
- Alarm1 = 06:30 with `Alarmwkday`: crossing 06:30 on Sat → no `Buzz`; on Mon → `Buzz`. Alarm0 and alarm1 both matching → `BuzzId` = 0. `Alarmoff` and `Snooze` in the same cycle → both IDLE.
- `Reset` low while RINGING → `Buzz` 0 next edge and all fields at reset values.
